// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit.
//   fwd_sel_e : EX operand source selector encoding (regfile / EX_MEM / MEM_WB)
//   slot_t    : one tracked in-flight instruction {valid, rd, regwrite, memread}
//   fwd_pick  : priority pick between an EX-slot and a MEM-slot match
package pipe_hazard_unit_pkg;

    // rd is stored at a fixed width so the record type does not depend on a
    // module parameter; REG_AW must not exceed this.
    localparam int SLOT_RD_W = 8;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // The youngest producer (EX) holds the newest value, so it wins.
    function automatic fwd_sel_e fwd_pick(input logic ex_match, input logic mem_match);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (ex_match) begin
            sel = FWD_EXMEM;
        end else if (mem_match) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bundle of the ID-stage request signals and the hazard-unit responses.
//   master : pipeline side; drives id_*, ex_redirect, cnt_clr
//   slave  : hazard unit; drives stall, flush, bubble, fwd_*_sel, *_cnt
interface pipe_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    import pipe_hazard_unit_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_redirect;
    logic              cnt_clr;

    logic              stall;
    logic              flush;
    logic              bubble;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, ex_redirect, cnt_clr,
        input  stall, flush, bubble, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, ex_redirect, cnt_clr,
        output stall, flush, bubble, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_unit_hazard_slot.sv
// One tracking register for an in-flight instruction plus its source compare.
//   clk, rst_n       : clock, asynchronous active-low reset (clears to invalid)
//   slot_d / slot_q  : next / current tracked record
//   rs1, rs2, use_*  : ID-stage sources to compare against
//   match_a/match_b  : this slot produces ID's rs1 / rs2
//   load_match       : this slot is a load and produces either source
module hazard_slot
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  slot_t             slot_d,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    output slot_t             slot_q,
    output logic              match_a,
    output logic              match_b,
    output logic              load_match
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    // x0 is hard-wired zero, so a write to it never produces a dependency.
    always_comb begin
        match_a    = slot_q.valid && slot_q.regwrite && use_rs1 &&
                     (rs1 != '0) && (slot_q.rd[REG_AW-1:0] == rs1);
        match_b    = slot_q.valid && slot_q.regwrite && use_rs2 &&
                     (rs2 != '0) && (slot_q.rd[REG_AW-1:0] == rs2);
        load_match = slot_q.memread && (match_a || match_b);
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks the instructions in EX and MEM, stalls ID on
// unresolvable RAW hazards, flushes on redirects, selects EX operand
// forwarding and counts stall / redirect cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   hz         : slave side of pipe_hazard_unit_if (ID request, responses)
// Parameters: REG_AW register index width, FWD_EN forwarding enable
// (0 = stall-only), LOAD_LAT extra load latency (1..2), CNT_W counter width.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_unit_if.slave  hz
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Index 0 = EX slot, index 1 = MEM slot.
    slot_t    slot_d [2];
    slot_t    slot_q [2];
    logic     match_a [2];
    logic     match_b [2];
    logic     load_match [2];

    logic     hazard;
    logic     stall_int;
    logic     advance;
    fwd_sel_e fwd_a_d, fwd_a_q;
    fwd_sel_e fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            hazard_slot #(.REG_AW(REG_AW)) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .slot_d     (slot_d[gi]),
                .rs1        (hz.id_rs1),
                .rs2        (hz.id_rs2),
                .use_rs1    (hz.id_use_rs1),
                .use_rs2    (hz.id_use_rs2),
                .slot_q     (slot_q[gi]),
                .match_a    (match_a[gi]),
                .match_b    (match_b[gi]),
                .load_match (load_match[gi])
            );
        end
    endgenerate

    always_comb begin
        // With forwarding only loads whose data is not yet available block ID;
        // without it any pending writer does.
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = load_match[0] || ((LOAD_LAT == 2) && load_match[1]);
        end else begin
            hazard = match_a[0] || match_b[0] || match_a[1] || match_b[1];
        end

        // A redirect kills ID, so it never needs to wait.
        stall_int = hazard && hz.id_valid && !hz.ex_redirect;
        advance   = hz.id_valid && !stall_int && !hz.ex_redirect;

        slot_d[0] = SLOT_EMPTY;
        if (advance) begin
            slot_d[0].valid    = 1'b1;
            slot_d[0].rd       = SLOT_RD_W'(hz.id_rd);
            slot_d[0].regwrite = hz.id_regwrite;
            slot_d[0].memread  = hz.id_memread;
        end
        slot_d[1] = slot_q[0];

        // Bubbles and killed instructions enter EX with no forwarding.
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (advance && (FWD_EN != 0)) begin
            fwd_a_d = fwd_pick(match_a[0], match_a[1]);
            fwd_b_d = fwd_pick(match_b[0], match_b[1]);
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_int && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (hz.ex_redirect && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall     = stall_int;
    assign hz.flush     = hz.ex_redirect;
    assign hz.bubble    = stall_int || hz.ex_redirect;
    assign hz.fwd_a_sel = fwd_a_q;
    assign hz.fwd_b_sel = fwd_b_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed scoreboard bench for pipe_hazard_unit. Four instances:
//   0: FWD_EN=1 LOAD_LAT=1 CNT_W=16   1: FWD_EN=1 LOAD_LAT=2 CNT_W=16
//   2: FWD_EN=0 LOAD_LAT=1 CNT_W=16   3: FWD_EN=0 LOAD_LAT=1 CNT_W=3
// Each cycle the active instance gets one ID instruction; the others idle.
module tb_pipe_hazard_unit;

    localparam int N_DUT = 4;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        int         k;
        logic       s;
        logic       f;
        logic       b;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_t      id_v    [N_DUT];
    logic        redir_v [N_DUT];
    logic        clr_v   [N_DUT];
    logic        stall_o [N_DUT];
    logic        flush_o [N_DUT];
    logic        bubble_o[N_DUT];
    logic [1:0]  fa_o    [N_DUT];
    logic [1:0]  fb_o    [N_DUT];
    logic [15:0] scnt_o  [N_DUT];
    logic [15:0] fcnt_o  [N_DUT];

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    generate
        for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
            localparam int FE = (gi >= 2) ? 0 : 1;
            localparam int LL = (gi == 1) ? 2 : 1;
            localparam int CW = (gi == 3) ? 3 : 16;

            pipe_hazard_unit_if #(.REG_AW(5), .CNT_W(CW)) u_if ();

            assign u_if.id_valid    = id_v[gi].v;
            assign u_if.id_rs1      = id_v[gi].rs1;
            assign u_if.id_rs2      = id_v[gi].rs2;
            assign u_if.id_use_rs1  = id_v[gi].u1;
            assign u_if.id_use_rs2  = id_v[gi].u2;
            assign u_if.id_rd       = id_v[gi].rd;
            assign u_if.id_regwrite = id_v[gi].rw;
            assign u_if.id_memread  = id_v[gi].mr;
            assign u_if.ex_redirect = redir_v[gi];
            assign u_if.cnt_clr     = clr_v[gi];

            pipe_hazard_unit #(
                .REG_AW(5), .FWD_EN(FE), .LOAD_LAT(LL), .CNT_W(CW)
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .hz    (u_if)
            );

            assign stall_o[gi]  = u_if.stall;
            assign flush_o[gi]  = u_if.flush;
            assign bubble_o[gi] = u_if.bubble;
            assign fa_o[gi]     = u_if.fwd_a_sel;
            assign fb_o[gi]     = u_if.fwd_b_sel;
            assign scnt_o[gi]   = 16'(u_if.stall_cnt);
            assign fcnt_o[gi]   = 16'(u_if.flush_cnt);
        end
    endgenerate

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic instr_t alu(input int rd, input int rs1, input int rs2);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
        i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t ld(input int rd, input int rs1);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1);
        i.u1 = 1'b1; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    // One ID cycle on instance k: expectations are queued when driven, then
    // popped and compared (combinational just before the edge, fwd selects
    // just after it).
    task automatic step(input int k, input string tag, input instr_t in,
                        input logic redir, input logic clr,
                        input logic es, input logic ef, input logic eb,
                        input logic [1:0] efa, input logic [1:0] efb);
        exp_t e;
        @(negedge clk);
        for (int j = 0; j < N_DUT; j++) begin
            id_v[j] = '0; redir_v[j] = 1'b0; clr_v[j] = 1'b0;
        end
        id_v[k] = in; redir_v[k] = redir; clr_v[k] = clr;
        e.k = k; e.s = es; e.f = ef; e.b = eb; e.fa = efa; e.fb = efb;
        sb_q.push_back(e);
        #4;
        e = sb_q.pop_front();
        check_val({tag, ".stall"},  32'(stall_o[e.k]),  32'(e.s));
        check_val({tag, ".flush"},  32'(flush_o[e.k]),  32'(e.f));
        check_val({tag, ".bubble"}, 32'(bubble_o[e.k]), 32'(e.b));
        @(posedge clk);
        #1;
        check_val({tag, ".fwd_a"}, 32'(fa_o[e.k]), 32'(e.fa));
        check_val({tag, ".fwd_b"}, 32'(fb_o[e.k]), 32'(e.fb));
        $display("dut%0d %-12s stall=%0b flush=%0b bubble=%0b fwd_a=%0d fwd_b=%0d scnt=%0d fcnt=%0d",
                 k, tag, stall_o[k], flush_o[k], bubble_o[k], fa_o[k], fb_o[k], scnt_o[k], fcnt_o[k]);
    endtask

    task automatic idle(input int k);
        step(k, "idle", '0, 1'b0, 1'b0, 0, 0, 0, 2'd0, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t i;
        for (int j = 0; j < N_DUT; j++) begin
            id_v[j] = '0; redir_v[j] = 1'b0; clr_v[j] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < N_DUT; j++) begin
            check_val($sformatf("rst%0d.stall", j),  32'(stall_o[j]),  0);
            check_val($sformatf("rst%0d.flush", j),  32'(flush_o[j]),  0);
            check_val($sformatf("rst%0d.bubble", j), 32'(bubble_o[j]), 0);
            check_val($sformatf("rst%0d.fwd_a", j),  32'(fa_o[j]),     0);
            check_val($sformatf("rst%0d.fwd_b", j),  32'(fb_o[j]),     0);
            check_val($sformatf("rst%0d.scnt", j),   32'(scnt_o[j]),   0);
            check_val($sformatf("rst%0d.fcnt", j),   32'(fcnt_o[j]),   0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // ALU forwarding: EX, MEM, and EX-over-MEM priority
        step(0, "s1_add5",   alu(5, 1, 2), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(0, "s1_sub6",   alu(6, 5, 1), 0, 0, 0, 0, 0, 2'd1, 2'd0);
        step(0, "s1_add9",   alu(9, 3, 4), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(0, "s1_add7m",  alu(7, 1, 6), 0, 0, 0, 0, 0, 2'd0, 2'd2);
        step(0, "s1_add7",   alu(7, 1, 2), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(0, "s1_add8",   alu(8, 7, 7), 0, 0, 0, 0, 0, 2'd1, 2'd1);
        idle(0); idle(0);

        // Load-use, LOAD_LAT=1
        step(0, "s2_lw5",    ld(5, 1),     0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(0, "s2_use",    alu(6, 5, 5), 0, 0, 1, 0, 1, 2'd0, 2'd0);
        step(0, "s2_use",    alu(6, 5, 5), 0, 0, 0, 0, 0, 2'd2, 2'd2);
        idle(0); idle(0);
        check_val("s2.stall_cnt", 32'(scnt_o[0]), 1);
        check_val("s2.flush_cnt", 32'(fcnt_o[0]), 0);

        // Load followed by an instruction that does not read rs2
        step(0, "s2b_lw5",   ld(5, 1),     0, 0, 0, 0, 0, 2'd0, 2'd0);
        i = alu(6, 1, 5); i.u2 = 1'b0;
        step(0, "s2b_nouse", i,            0, 0, 0, 0, 0, 2'd0, 2'd0);
        idle(0); idle(0);

        // Load-use, LOAD_LAT=2
        step(1, "s3_lw5",    ld(5, 1),     0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(1, "s3_use",    alu(6, 5, 5), 0, 0, 1, 0, 1, 2'd0, 2'd0);
        step(1, "s3_use",    alu(6, 5, 5), 0, 0, 1, 0, 1, 2'd0, 2'd0);
        step(1, "s3_use",    alu(6, 5, 5), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        idle(1); idle(1);
        check_val("s3.stall_cnt", 32'(scnt_o[1]), 2);

        // Stall-only configuration
        step(2, "s4_add5",   alu(5, 1, 2), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(2, "s4_use",    alu(7, 5, 0), 0, 0, 1, 0, 1, 2'd0, 2'd0);
        step(2, "s4_use",    alu(7, 5, 0), 0, 0, 1, 0, 1, 2'd0, 2'd0);
        step(2, "s4_use",    alu(7, 5, 0), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        idle(2); idle(2);
        check_val("s4.stall_cnt", 32'(scnt_o[2]), 2);

        // Redirect overrides a load-use stall
        step(0, "s5_lw5",    ld(5, 1),     0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(0, "s5_redir",  alu(6, 5, 5), 1, 0, 0, 1, 1, 2'd0, 2'd0);
        idle(0); idle(0);
        check_val("s5.flush_cnt", 32'(fcnt_o[0]), 1);
        check_val("s5.stall_cnt", 32'(scnt_o[0]), 1);

        // x0 never creates a dependency
        step(0, "s6_wr_x0",  alu(0, 1, 2), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(0, "s6_rd_x0",  alu(6, 0, 0), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(2, "s6n_wr_x0", alu(0, 1, 2), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(2, "s6n_rd_x0", alu(6, 0, 0), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        idle(0); idle(2);

        // Saturation on the 3-bit counters: 8 stall cycles, 9 redirects
        for (int p = 0; p < 4; p++) begin
            step(3, "sat_add5", alu(5, 1, 2), 0, 0, 0, 0, 0, 2'd0, 2'd0);
            step(3, "sat_use",  alu(7, 5, 0), 0, 0, 1, 0, 1, 2'd0, 2'd0);
            step(3, "sat_use",  alu(7, 5, 0), 0, 0, 1, 0, 1, 2'd0, 2'd0);
            step(3, "sat_use",  alu(7, 5, 0), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        end
        check_val("sat.stall_cnt", 32'(scnt_o[3]), 7);
        for (int p = 0; p < 9; p++) begin
            step(3, "sat_redir", '0, 1, 0, 0, 1, 1, 2'd0, 2'd0);
        end
        check_val("sat.flush_cnt", 32'(fcnt_o[3]), 7);

        // Clear wins over increment during a stall
        step(3, "clr_add5",  alu(5, 1, 2), 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(3, "clr_use",   alu(7, 5, 0), 0, 1, 1, 0, 1, 2'd0, 2'd0);
        check_val("clr.stall_cnt", 32'(scnt_o[3]), 0);
        check_val("clr.flush_cnt", 32'(fcnt_o[3]), 0);
        step(3, "clr_use2",  alu(7, 5, 0), 0, 0, 1, 0, 1, 2'd0, 2'd0);
        check_val("clr.stall_cnt2", 32'(scnt_o[3]), 1);
        step(3, "clr_go",    alu(7, 5, 0), 0, 0, 0, 0, 0, 2'd0, 2'd0);

        // Reset asserted in the middle of a stall
        idle(0); idle(0);
        step(0, "rs_lw5",    ld(5, 1),     0, 0, 0, 0, 0, 2'd0, 2'd0);
        @(negedge clk);
        id_v[0] = alu(6, 5, 5);
        #2;
        check_val("rs.stall_before", 32'(stall_o[0]), 1);
        rst_n = 1'b0;
        #1;
        check_val("rs.stall_after",  32'(stall_o[0]),  0);
        check_val("rs.bubble_after", 32'(bubble_o[0]), 0);
        check_val("rs.stall_cnt",    32'(scnt_o[0]),   0);
        check_val("rs.flush_cnt",    32'(fcnt_o[0]),   0);
        $display("dut0 %-12s stall=%0b bubble=%0b", "rst_mid", stall_o[0], bubble_o[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
